// File: rtl/twos_to_sign_mag_serial.sv
// ---------------------------------------------------------------------------
// twos_to_sign_mag_serial
//
// Converts a WIDTH-bit two's-complement word into sign-magnitude form, one
// bit per clock, LSB first. Negative words are negated with the
// copy-until-first-one-then-invert rule. Positive words are copied unchanged.
//
// Ports
//   clk        system clock, rising-edge state updates
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a word to convert
//   in_ready   block can accept a word (high only in IDLE)
//   in_data    two's-complement operand
//   out_valid  out_sign/out_mag hold a finished result
//   out_ready  consumer accepts the result
//   out_sign   1 = operand was negative
//   out_mag    unsigned magnitude of the operand
//   busy       high while bits are being converted
//
// Handshake semantics (both sides): a transfer happens on the rising edge
// where valid and ready are both high. A producer never withdraws valid
// before that edge. Results are held stable while out_valid is high.
// in_valid is ignored whenever in_ready is low.
// ---------------------------------------------------------------------------
module twos_to_sign_mag_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] src;
    logic [CW-1:0]   cnt;
    logic            seen_one;
    logic            sign;
    logic            r_bit;

    // Once a negative operand has passed its lowest 1, every further bit is
    // inverted. The first 1 itself is copied because seen_one is only set
    // after that bit has been consumed.
    assign r_bit = (sign && seen_one) ? ~src[0] : src[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            src       <= '0;
            cnt       <= '0;
            seen_one  <= 1'b0;
            sign      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_mag   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is registered, so it rises on the first edge
                    // after reset release and no word is taken on that edge.
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        src      <= in_data;
                        sign     <= in_data[WIDTH-1];
                        cnt      <= '0;
                        seen_one <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end

                CONV: begin
                    // Result bits enter at the MSB so that after WIDTH edges
                    // the first processed bit lands in out_mag[0].
                    out_mag  <= {r_bit, out_mag[WIDTH-1:1]};
                    src      <= src >> 1;
                    seen_one <= seen_one | src[0];
                    if (cnt == LAST_BIT) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_sign  <= sign;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DONE: begin
                    // out_sign/out_mag are left untouched after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twos_to_sign_mag_serial.sv
// ---------------------------------------------------------------------------
// tb_twos_to_sign_mag_serial
//
// Self-checking bench for twos_to_sign_mag_serial (WIDTH=8). Directed words
// with literal expectations, backpressure, mid-conversion reset and a
// shuffled sweep of all 256 inputs with random output stalls. A monitor
// compares every result against a signed-arithmetic model.
// ---------------------------------------------------------------------------
module tb_twos_to_sign_mag_serial;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [W-1:0] out_mag;
    logic         busy;

    twos_to_sign_mag_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .busy      (busy)
    );

    // ------------------------------------------------------------ clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ------------------------------------------------------------ bookkeeping
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------ model
    // {sign, magnitude} from the signed value of the word.
    function automatic logic [W:0] model(input logic [W-1:0] d);
        int v;
        int m;
        v = int'($signed(d));
        m = (v < 0) ? -v : v;
        return {d[W-1], m[W-1:0]};
    endfunction

    // ------------------------------------------------------------ scoreboard
    logic [W:0] exp_q[$];
    int         acc_q[$];
    logic [W:0] cur;
    logic       prev_valid = 1'b0;
    logic       hs_pend    = 1'b0;

    always @(negedge clk) begin
        int a;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            prev_valid = 1'b0;
            hs_pend    = 1'b0;
        end else begin
            if (hs_pend) begin
                check("in_ready_after_hs", in_ready, 1);
                check("out_valid_after_hs", out_valid, 0);
                hs_pend = 1'b0;
            end
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    fail("spurious_output");
                end else begin
                    cur = exp_q.pop_front();
                    a   = acc_q.pop_front();
                    check("latency", cyc - a, W);
                    check("result", {out_sign, out_mag}, cur);
                end
            end else if (out_valid) begin
                check("result_hold", {out_sign, out_mag}, cur);
            end
            if (out_valid || busy) check("in_ready_low", in_ready, 0);
            if (out_valid && out_ready) hs_pend = 1'b1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data));
                acc_q.push_back(cyc + 1);
            end
            prev_valid = out_valid;
        end
    end

    // ------------------------------------------------------------ drivers
    logic rand_rdy = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [W-1:0] d);
        int k;
        k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) fail("send_timeout");
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    task automatic wait_out_valid(input string name);
        int k;
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!out_valid) fail(name);
    endtask

    task automatic wait_in_ready(input string name);
        int k;
        k = 0;
        while (!in_ready && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) fail(name);
    endtask

    // Directed word with out_ready high: literal expectation on the result.
    task automatic do_word(input logic [W-1:0] d, input logic [W:0] exp);
        send(d);
        wait_out_valid("out_valid_timeout");
        check($sformatf("lit_%02h", d), {out_sign, out_mag}, exp);
        wait_in_ready("in_ready_timeout");
    endtask

    // ------------------------------------------------------------ main
    logic [W-1:0] words[256];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Model pinned to hand-computed values.
        check("model_fb", model(8'hFB), 9'h105);
        check("model_80", model(8'h80), 9'h180);
        check("model_ff", model(8'hFF), 9'h101);
        check("model_9c", model(8'h9C), 9'h164);
        check("model_7f", model(8'h7F), 9'h07F);

        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_mag", out_mag, 0);
        check("rst_out_sign", out_sign, 0);
        #21;
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("in_ready_after_release", in_ready, 1);

        // Directed words; out_ready held high in advance.
        out_ready = 1'b1;
        do_word(8'hFB, 9'h105);
        do_word(8'h05, 9'h005);
        do_word(8'h00, 9'h000);
        do_word(8'h7F, 9'h07F);
        do_word(8'h80, 9'h180);
        do_word(8'hFF, 9'h101);

        // Backpressure with an ignored second word.
        out_ready = 1'b0;
        send(8'h9C);
        wait_out_valid("bp_timeout");
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 1 || i == 2);
            in_data  = 8'h11;
            check("bp_valid", out_valid, 1);
            check("bp_result", {out_sign, out_mag}, 9'h164);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_in_ready("bp_release_timeout");

        // Reset in the middle of a conversion.
        send(8'hC8);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_mag", out_mag, 0);
        check("mid_rst_out_sign", out_sign, 0);
        #12;
        rst_n = 1'b1;
        wait_in_ready("post_rst_timeout");
        do_word(8'h38, 9'h038);

        // Shuffled sweep of every input with random output stalls.
        for (int i = 0; i < 256; i++) words[i] = W'(i);
        for (int i = 255; i > 0; i--) begin
            int j;
            logic [W-1:0] t;
            j        = $urandom_range(0, i);
            t        = words[i];
            words[i] = words[j];
            words[j] = t;
        end
        rand_rdy = 1'b1;
        for (int i = 0; i < 256; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
            send(words[i]);
        end
        begin
            int k;
            k = 0;
            while ((exp_q.size() != 0 || !in_ready) && k < 500) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("all_results_delivered", exp_q.size(), 0);
        check("final_idle", in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
